// File: rtl/cache_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single cacheline adaptor.
// Arbitration is fixed D-priority unless CACHE_ARB_ROUND_ROBIN_EN is defined.
module cache_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_address,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [ADDR_W-1:0] d_address,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp,
   // FSM state for observation: 0 IDLE, 1 SERVE_I, 2 SERVE_D, 3 DONE
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DONE    = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic              d_req;
   logic              any_req;
   logic              grant_d;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
   // 1 = I port was served last; reset value lets D win the first tie.
   logic              last_i_q, last_i_d;
`endif

   // Handshake: a request is a level held by the cache; it is sampled only in
   // IDLE. The transaction completes when mem_resp=1 in SERVE_x, which is
   // passed straight through to the granted x_resp in the same cycle.
   always_comb begin
      d_req   = d_read | d_write;
      any_req = i_read | d_req;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      grant_d = d_req & (~i_read | last_i_q);
`else
      grant_d = d_req;
`endif
   end

   always_comb begin
      state_d       = state_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      mem_read_d    = mem_read_q;
      mem_write_d   = mem_write_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_i_d      = last_i_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
               last_i_d = ~grant_d;
`endif
               if (grant_d) begin
                  state_d       = SERVE_D;
                  mem_address_d = d_address;
                  mem_wdata_d   = d_wdata;
                  // A simultaneous read and write resolves to the write-back.
                  mem_write_d   = d_write;
                  mem_read_d    = ~d_write;
               end else begin
                  state_d       = SERVE_I;
                  mem_address_d = i_address;
                  mem_write_d   = 1'b0;
                  mem_read_d    = 1'b1;
               end
            end
         end
         SERVE_I, SERVE_D: begin
            if (mem_resp) begin
               state_d     = DONE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         mem_read_q    <= 1'b0;
         mem_write_q   <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
         last_i_q      <= 1'b1;
`endif
      end else begin
         state_q       <= state_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_read_q    <= mem_read_d;
         mem_write_q   <= mem_write_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
         last_i_q      <= last_i_d;
`endif
      end
   end

   assign mem_address = mem_address_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign i_rdata     = mem_rdata;
   assign d_rdata     = mem_rdata;
   assign i_resp      = ~rst & (state_q == SERVE_I) & mem_resp;
   assign d_resp      = ~rst & (state_q == SERVE_D) & mem_resp;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed-plus-random bench for cache_arbiter; the bench plays the adaptor and
// predicts grants from the arbitration rules (fixed D-priority or round robin).
module tb_cache_arbiter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
   localparam bit RR_MODE = 1'b1;
`else
   localparam bit RR_MODE = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] i_address, d_address, mem_address;
   logic              i_read, d_read, d_write;
   logic [LINE_W-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
   logic              i_resp, d_resp, mem_read, mem_write, mem_resp;
   logic [1:0]        dbg_state;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [LINE_W-1:0] exp_q[$];
   bit last_i_served;

   cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst(rst),
      .i_address(i_address), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] v;
      for (int w = 0; w < LINE_W / 32; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                      input logic [LINE_W-1:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts at an IDLE negedge; returns at the IDLE negedge after DONE.
   // late_d raises d_read (address late_da) while the I transaction is in flight.
   task automatic serve(input bit ir, input bit dr, input bit dw,
                        input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                        input logic [LINE_W-1:0] wd, input int lat, input bit drop,
                        input bit late_d, input logic [ADDR_W-1:0] late_da);
      bit win_d, exp_wr;
      logic [ADDR_W-1:0] exp_addr;
      logic [LINE_W-1:0] rd;
      i_read = ir; d_read = dr; d_write = dw;
      i_address = ia; d_address = da; d_wdata = wd; mem_resp = 1'b0;
      if (ir && (dr || dw)) win_d = RR_MODE ? last_i_served : 1'b1;
      else win_d = dr || dw;
      last_i_served = !win_d;
      exp_wr   = win_d && dw;
      exp_addr = win_d ? da : ia;
      @(negedge clk);
      if (drop) begin
         i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
         i_address = $urandom; d_address = $urandom; d_wdata = rand_line();
      end
      for (int k = 0; k < lat; k++) begin
         #1;
         chk("serve_state", dbg_state, win_d ? 2'd2 : 2'd1);
         chk("serve_mem_read", mem_read, !exp_wr);
         chk("serve_mem_write", mem_write, exp_wr);
         chk("serve_mem_address", mem_address, exp_addr);
         if (exp_wr) chk("serve_mem_wdata", mem_wdata, wd);
         chk("wait_i_resp", i_resp, 1'b0);
         chk("wait_d_resp", d_resp, 1'b0);
         if (late_d && k == 0) begin
            d_read = 1'b1; d_address = late_da;
         end
         @(negedge clk);
      end
      rd = rand_line();
      exp_q.push_back(rd);
      mem_rdata = rd; mem_resp = 1'b1;
      #1;
      chk("resp_i_resp", i_resp, !win_d);
      chk("resp_d_resp", d_resp, win_d);
      chk("resp_strobe", win_d && dw ? mem_write : mem_read, 1'b1);
      chk("resp_rdata", win_d ? d_rdata : i_rdata, exp_q.pop_front());
      if (win_d) begin d_read = 1'b0; d_write = 1'b0; end
      else i_read = 1'b0;
      @(negedge clk);
      mem_resp = 1'b1; mem_rdata = rand_line();
      #1;
      chk("done_state", dbg_state, 2'd3);
      chk("done_mem_read", mem_read, 1'b0);
      chk("done_mem_write", mem_write, 1'b0);
      chk("done_i_resp", i_resp, 1'b0);
      chk("done_d_resp", d_resp, 1'b0);
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      chk("idle_state", dbg_state, 2'd0);
      chk("idle_strobes", {mem_read, mem_write}, 2'b00);
   endtask

   initial begin
      logic [ADDR_W-1:0] ia, da;
      logic [LINE_W-1:0] wb;
      bit ir, dr, dw;
      rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      i_address = '0; d_address = '0; d_wdata = '0;
      mem_rdata = rand_line(); mem_resp = 1'b1;
      last_i_served = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_i_resp", i_resp, 1'b0);
      chk("rst_d_resp", d_resp, 1'b0);
      chk("rst_state", dbg_state, 2'd0);
      chk("rst_strobes", {mem_read, mem_write}, 2'b00);
      chk("rst_address", mem_address, '0);
      chk("rst_wdata", mem_wdata, '0);
      rst = 1'b0; mem_resp = 1'b0;

      // Instruction fetch with a 10-cycle adaptor latency.
      serve(1, 0, 0, 32'h0000_1000, '0, rand_line(), 10, 0, 0, '0);
      // Data write-back.
      wb = rand_line();
      serve(0, 0, 1, $urandom, 32'h8000_0020, wb, $urandom_range(1, 5), 0, 0, '0);
      // Simultaneous requests, both held: three rounds.
      for (int r = 0; r < 3; r++) begin
         ia = $urandom; da = $urandom;
         serve(1, 1, 0, ia, da, rand_line(), $urandom_range(1, 4), 0, 0, '0);
         if (last_i_served) serve(0, 1, 0, ia, da, rand_line(), $urandom_range(1, 4), 0, 0, '0);
         else serve(1, 0, 0, ia, da, rand_line(), $urandom_range(1, 4), 0, 0, '0);
      end
      // Read and write together resolve to a write; requests dropped after grant.
      wb = rand_line();
      serve(0, 1, 1, $urandom, $urandom, wb, $urandom_range(1, 4), 1, 0, '0);
      // Spurious mem_resp in IDLE.
      mem_resp = 1'b1;
      #1;
      chk("spur_i_resp", i_resp, 1'b0);
      chk("spur_d_resp", d_resp, 1'b0);
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      chk("spur_state", dbg_state, 2'd0);
      chk("spur_strobes", {mem_read, mem_write}, 2'b00);

      // A D request arriving mid-transaction waits, then is served.
      da = $urandom;
      serve(1, 0, 0, $urandom, '0, rand_line(), 3, 0, 1, da);
      serve(0, 1, 0, $urandom, da, rand_line(), 2, 0, 0, '0);
      // A request withdrawn before its grant leaves the arbiter idle.
      serve(1, 0, 0, $urandom, '0, rand_line(), 2, 0, 1, $urandom);
      d_read = 1'b0;
      @(negedge clk);
      #1;
      chk("withdrawn_state", dbg_state, 2'd0);
      chk("withdrawn_strobes", {mem_read, mem_write}, 2'b00);

      // Reset in the middle of a D read.
      d_read = 1'b1; d_address = $urandom;
      @(negedge clk);
      #1;
      chk("pre_rst_mem_read", mem_read, 1'b1);
      d_read = 1'b0;
      @(negedge clk);
      rst = 1'b1; mem_resp = 1'b1;
      #1;
      chk("in_rst_d_resp", d_resp, 1'b0);
      chk("in_rst_i_resp", i_resp, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_state", dbg_state, 2'd0);
      chk("post_rst_strobes", {mem_read, mem_write}, 2'b00);
      chk("post_rst_address", mem_address, '0);
      chk("late_resp_d_resp", d_resp, 1'b0);
      @(negedge clk);
      mem_resp = 1'b0;
      #1;
      chk("post_rst_idle", dbg_state, 2'd0);
      last_i_served = 1'b1;
      // First tie after reset goes to D in either policy.
      serve(1, 1, 0, $urandom, $urandom, rand_line(), 2, 1, 0, '0);

      // Random request mixes.
      for (int n = 0; n < 24; n++) begin
         ir = $urandom_range(0, 1); dr = $urandom_range(0, 1); dw = $urandom_range(0, 1);
         if (!ir && !dr && !dw) ir = 1'b1;
         serve(ir, dr, dw, $urandom, $urandom, rand_line(), $urandom_range(1, 6),
               $urandom_range(0, 1), 0, '0);
      end
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width in bits.
REQ-002 SHALL have parameter LINE_W, default 256, meaning the cacheline width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_address  input  ADDR_W  instruction-cache line address.
REQ-006 SHALL have port i_read  input  1  instruction-cache read request.
REQ-007 SHALL have port i_rdata  output  LINE_W  line returned to the instruction cache.
REQ-008 SHALL have port i_resp  output  1  instruction-cache completion pulse.
REQ-009 SHALL have port d_address  input  ADDR_W  data-cache line address.
REQ-010 SHALL have port d_read  input  1  data-cache read request.
REQ-011 SHALL have port d_write  input  1  data-cache write-back request.
REQ-012 SHALL have port d_wdata  input  LINE_W  write-back line from the data cache.
REQ-013 SHALL have port d_rdata  output  LINE_W  line returned to the data cache.
REQ-014 SHALL have port d_resp  output  1  data-cache completion pulse.
REQ-015 SHALL have port mem_address  output  ADDR_W  address to the cacheline adaptor.
REQ-016 SHALL have port mem_read / mem_write  output  1 each  request strobes to the adaptor.
REQ-017 SHALL have port mem_wdata  output  LINE_W  line to the adaptor.
REQ-018 SHALL have port mem_rdata  input  LINE_W  line from the adaptor.
REQ-019 SHALL have port mem_resp  input  1  adaptor completion pulse.

Function
REQ-020 SHALL implement the FSM states IDLE, SERVE_I, SERVE_D and DONE.
REQ-021 In IDLE, a request (i_read, d_read or d_write) SHALL cause a grant and a transition to SERVE_I or SERVE_D on the next edge.
  - At the same edge, mem_address, mem_wdata and the operation SHALL be latched from the granted port.
REQ-022 mem_read/mem_write SHALL be registered outputs, high throughout SERVE_x and low in IDLE and DONE.
  - Latency from request in IDLE to strobe high: 1 cycle.
REQ-023 In SERVE_x, when mem_resp=1:
  - the granted port's x_resp SHALL be 1 in that same cycle (combinational pass-through);
  - x_rdata SHALL equal mem_rdata;
  - the FSM SHALL move to DONE.
REQ-024 DONE SHALL last exactly 1 cycle with both strobes low, then return to IDLE, giving the adaptor a guaranteed idle gap.
REQ-025 i_resp and d_resp SHALL never both be 1; the ungranted resp SHALL be 0 regardless of mem_resp.
REQ-026 i_rdata and d_rdata SHALL both be driven from mem_rdata; they are valid only while the matching x_resp=1.
REQ-027 Requests arriving during SERVE_x or DONE SHALL wait; they are not latched until IDLE.
REQ-028 A request deasserted before its grant SHALL be ignored.
  - A request deasserted after grant SHALL still complete on the latched values, and x_resp SHALL still pulse.
REQ-029 If d_read and d_write are both 1 at grant, the operation SHALL be a write.
REQ-030 mem_resp received in IDLE or DONE SHALL be ignored.
REQ-031 Both i_read and d_read/d_write at 1 in IDLE (simultaneous requests) SHALL be resolved per REQ-036/037.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE and clear mem_read, mem_write, mem_address and mem_wdata to 0.
REQ-033 During reset, i_resp and d_resp SHALL be 0; the round-robin pointer SHALL indicate "I served last".
REQ-034 Reset during SERVE_x SHALL abandon the transaction with no x_resp; a late mem_resp is ignored per REQ-030.

Configuration
REQ-035 Macro CACHE_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-036 Without CACHE_ARB_ROUND_ROBIN_EN: fixed priority, and on simultaneous requests the D port always wins.
REQ-037 With CACHE_ARB_ROUND_ROBIN_EN:
  - a 1-bit last-served pointer SHALL update on each grant;
  - on simultaneous requests, the port not served last SHALL win;
  - after reset the D port SHALL win first.

Verification
REQ-038 i_read=1, i_address=0x0000_1000, mem_resp 10 cycles later with mem_rdata=A -> mem_read high 1 cycle after request; i_resp=1 and i_rdata=A in the mem_resp cycle; mem_read low the next cycle.
REQ-039 d_write=1, d_address=0x8000_0020, d_wdata=B -> mem_write=1, mem_address=0x8000_0020, mem_wdata=B until mem_resp; d_resp pulses; i_resp stays 0.
REQ-040 i_read and d_read high in the same IDLE cycle, both held -> D served first, then I; 1-cycle DONE gap between the two; with CACHE_ARB_ROUND_ROBIN_EN, two further simultaneous rounds alternate D, I.
REQ-041 rst=1 for 1 cycle mid SERVE_D, followed by mem_resp -> strobes low after the edge, no d_resp, FSM in IDLE.
REQ-042 d_read and d_write both 1 -> mem_write=1, mem_read=0; spurious mem_resp in IDLE -> no x_resp.
